// File: rtl/vred_logic_tree.sv
// Pipelined multi-lane AND/OR/XOR vector reduction.
//   Each beat of LANES elements is masked (inactive lanes take the identity),
//   reduced through log2(LANES) registered pairwise levels, then folded into an
//   accumulator across the beats of one reduction. A finished reduction is
//   presented on out_vec with a one-cycle out_valid pulse.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   in_valid        beat present; in_first/in_last/in_opSel/in_mask/in_vec qualify it
//   in_opSel        01=and 10=or 11=xor 00=zero, taken from the opening beat
//   out_valid       one-cycle pulse with a finished result on out_vec
//   out_vec         result, held until the next out_valid
//   out_busy        reduction open or work in flight
module vred_logic_tree #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LANES       = 4,
    parameter int unsigned OPSEL_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          in_first,
    input  logic                          in_last,
    input  logic [OPSEL_WIDTH-1:0]        in_opSel,
    input  logic [LANES-1:0]              in_mask,
    input  logic [LANES*DATA_WIDTH-1:0]   in_vec,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_vec,
    output logic                          out_busy
);

    localparam int unsigned S      = $clog2(LANES);
    localparam int unsigned TREE_W = (2 * LANES - 1) * DATA_WIDTH;

    localparam logic [OPSEL_WIDTH-1:0] OP_ZERO = OPSEL_WIDTH'(0);
    localparam logic [OPSEL_WIDTH-1:0] OP_AND  = OPSEL_WIDTH'(1);
    localparam logic [OPSEL_WIDTH-1:0] OP_OR   = OPSEL_WIDTH'(2);
    localparam logic [OPSEL_WIDTH-1:0] OP_XOR  = OPSEL_WIDTH'(3);

    // Combine two elements; opcode 00 always yields zero.
    function automatic logic [DATA_WIDTH-1:0] op_apply(
        input logic [OPSEL_WIDTH-1:0] op,
        input logic [DATA_WIDTH-1:0]  a,
        input logic [DATA_WIDTH-1:0]  b
    );
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return '0;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] identity(input logic [OPSEL_WIDTH-1:0] op);
        return (op == OP_AND) ? '1 : '0;
    endfunction

    // Element offset of tree level k inside the flattened level storage.
    function automatic int unsigned lvl_off(input int unsigned k);
        int unsigned o;
        o = 0;
        for (int unsigned i = 0; i < k; i++) o += LANES >> i;
        return o;
    endfunction

    // Input-side reduction tracking so every beat enters the tree with the
    // reduction's opcode (masked lanes of later beats need its identity).
    logic                   in_open_q, in_open_d;
    logic [OPSEL_WIDTH-1:0] in_op_q, in_op_d;
    logic                   beat_first;
    logic [OPSEL_WIDTH-1:0] beat_op;

    always_comb begin
        beat_first = in_first | ~in_open_q;
        beat_op    = beat_first ? in_opSel : in_op_q;
        in_open_d  = in_open_q;
        in_op_d    = in_op_q;
        if (in_valid) begin
            in_open_d = ~in_last;
            if (beat_first) in_op_d = in_opSel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_open_q <= 1'b0;
            in_op_q   <= '0;
        end else begin
            in_open_q <= in_open_d;
            in_op_q   <= in_op_d;
        end
    end

    // Level 0 is the combinational masked beat; levels 1..S are registered.
    logic [TREE_W-1:0]                tree_data;
    logic [S:0]                       tree_vld;
    logic [S:0]                       tree_fst;
    logic [S:0]                       tree_lst;
    logic [S:0][OPSEL_WIDTH-1:0]      tree_op;

    for (genvar k = 0; k <= S; k++) begin : g_lvl
        localparam int unsigned N   = LANES >> k;
        localparam int unsigned OFF = lvl_off(k);

        if (k == 0) begin : g_in
            logic [N*DATA_WIDTH-1:0] lane_data;

            // Inactive lanes (or opcode 00) contribute the identity element.
            always_comb begin
                lane_data = '0;
                for (int i = 0; i < int'(N); i++) begin
                    lane_data[i*DATA_WIDTH +: DATA_WIDTH] =
                        (in_mask[i] && (beat_op != OP_ZERO))
                            ? in_vec[i*DATA_WIDTH +: DATA_WIDTH]
                            : identity(beat_op);
                end
            end

            assign tree_data[OFF*DATA_WIDTH +: N*DATA_WIDTH] = lane_data;
            assign tree_vld[k] = in_valid;
            assign tree_fst[k] = beat_first;
            assign tree_lst[k] = in_last;
            assign tree_op[k]  = beat_op;
        end else begin : g_reg
            localparam int unsigned POFF = lvl_off(k - 1);

            logic [2*N*DATA_WIDTH-1:0] pair_data;
            logic [N*DATA_WIDTH-1:0]   data_d, data_q;
            logic                      vld_q, fst_q, lst_q;
            logic [OPSEL_WIDTH-1:0]    op_q;

            assign pair_data = tree_data[POFF*DATA_WIDTH +: 2*N*DATA_WIDTH];

            // Combine adjacent pairs of the previous level.
            always_comb begin
                data_d = '0;
                for (int j = 0; j < int'(N); j++) begin
                    data_d[j*DATA_WIDTH +: DATA_WIDTH] =
                        op_apply(tree_op[k-1],
                                 pair_data[(2*j)*DATA_WIDTH +: DATA_WIDTH],
                                 pair_data[(2*j+1)*DATA_WIDTH +: DATA_WIDTH]);
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_q <= '0;
                    vld_q  <= 1'b0;
                    fst_q  <= 1'b0;
                    lst_q  <= 1'b0;
                    op_q   <= '0;
                end else begin
                    data_q <= data_d;
                    vld_q  <= tree_vld[k-1];
                    fst_q  <= tree_fst[k-1];
                    lst_q  <= tree_lst[k-1];
                    op_q   <= tree_op[k-1];
                end
            end

            assign tree_data[OFF*DATA_WIDTH +: N*DATA_WIDTH] = data_q;
            assign tree_vld[k] = vld_q;
            assign tree_fst[k] = fst_q;
            assign tree_lst[k] = lst_q;
            assign tree_op[k]  = op_q;
        end
    end

    logic [DATA_WIDTH-1:0]  t_data;
    assign t_data = tree_data[lvl_off(S)*DATA_WIDTH +: DATA_WIDTH];

    // Accumulator stage: folds tree results across beats, emits on last.
    logic [DATA_WIDTH-1:0]  acc_q, acc_d;
    logic [OPSEL_WIDTH-1:0] acc_op_q, acc_op_d;
    logic                   open_q, open_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_vec_q, out_vec_d;
    logic                   out_busy_q, out_busy_d;
    logic                   acc_first;
    logic [DATA_WIDTH-1:0]  acc_val;

    always_comb begin
        acc_d       = acc_q;
        acc_op_d    = acc_op_q;
        open_d      = open_q;
        out_valid_d = 1'b0;
        out_vec_d   = out_vec_q;
        acc_first   = tree_fst[S] | ~open_q;
        acc_val     = acc_first ? t_data : op_apply(acc_op_q, acc_q, t_data);
        if (tree_vld[S]) begin
            acc_d    = acc_val;
            acc_op_d = acc_first ? tree_op[S] : acc_op_q;
            if (tree_lst[S]) begin
                out_vec_d   = acc_val;
                out_valid_d = 1'b1;
                open_d      = 1'b0;
            end else begin
                open_d      = 1'b1;
            end
        end
        // Level S being valid always shows up in out_valid_d or open_d.
        out_busy_d = (|tree_vld) | out_valid_d | open_d | in_open_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            acc_op_q    <= '0;
            open_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            out_busy_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_op_q    <= acc_op_d;
            open_q      <= open_d;
            out_valid_q <= out_valid_d;
            out_vec_q   <= out_vec_d;
            out_busy_q  <= out_busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_vec   = out_vec_q;
    assign out_busy  = out_busy_q;

endmodule

// File: tb/tb_vred_logic_tree.sv
// Scoreboard bench for vred_logic_tree (DATA_WIDTH=32, LANES=4).
// The driver folds each beat into a reference result and queues the expected
// value with its due cycle; the monitor pops and compares on out_valid.
module tb_vred_logic_tree;

    localparam int unsigned DW  = 32;
    localparam int unsigned L   = 4;
    localparam int unsigned OW  = 2;
    localparam int          LAT = 3;

    localparam logic [1:0] ZRO = 2'b00;
    localparam logic [1:0] AND = 2'b01;
    localparam logic [1:0] OR  = 2'b10;
    localparam logic [1:0] XOR = 2'b11;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_first = 1'b0;
    logic            in_last  = 1'b0;
    logic [OW-1:0]   in_opSel = '0;
    logic [L-1:0]    in_mask  = '0;
    logic [L*DW-1:0] in_vec   = '0;
    logic            out_valid;
    logic [DW-1:0]   out_vec;
    logic            out_busy;

    always #5 clk = ~clk;

    vred_logic_tree #(.DATA_WIDTH(DW), .LANES(L), .OPSEL_WIDTH(OW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .in_opSel(in_opSel), .in_mask(in_mask),
        .in_vec(in_vec), .out_valid(out_valid), .out_vec(out_vec),
        .out_busy(out_busy)
    );

    typedef struct {
        logic [DW-1:0] val;
        int            due;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [DW-1:0] last_exp = '0;

    // Reference reduction state
    bit            m_open = 1'b0;
    logic [1:0]    m_op = '0;
    logic [DW-1:0] m_acc = '0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: sample just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        chk("spurious_out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_cycle", 32'(cyc), 32'(e.due));
                        chk("out_vec", out_vec, e.val);
                        last_exp = e.val;
                    end
                end else begin
                    if (sb.size() != 0 && sb[0].due < cyc) begin
                        chk("missed_out_valid", 32'(out_valid), 32'd1);
                        void'(sb.pop_front());
                    end
                    chk("out_vec_hold", out_vec, last_exp);
                end
            end
        end
    end

    // Reference: fold active lanes with the reduction's opcode.
    task automatic model(input bit f, input bit l, input logic [1:0] op,
                         input logic [L-1:0] m, input logic [L*DW-1:0] v);
        exp_t e;
        logic [DW-1:0] lane;
        if (f || !m_open) begin
            m_op  = op;
            m_acc = (op == AND) ? 32'hFFFF_FFFF : 32'h0;
        end
        for (int i = 0; i < int'(L); i++) begin
            lane = v[i*DW +: DW];
            if (m[i]) begin
                case (m_op)
                    AND:     m_acc = m_acc & lane;
                    OR:      m_acc = m_acc | lane;
                    XOR:     m_acc = m_acc ^ lane;
                    default: m_acc = 32'h0;
                endcase
            end
        end
        if (l) begin
            e.val = (m_op == ZRO) ? 32'h0 : m_acc;
            e.due = cyc + LAT;
            sb.push_back(e);
        end
        m_open = !l;
    endtask

    task automatic send(input bit f, input bit l, input logic [1:0] op,
                        input logic [L-1:0] m, input logic [L*DW-1:0] v);
        @(negedge clk);
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        in_opSel = op;
        in_mask  = m;
        in_vec   = v;
        model(f, l, op, m, v);
    endtask

    // Idle cycles carry junk on the qualified inputs.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_first = 1'($urandom);
            in_last  = 1'($urandom);
            in_opSel = 2'($urandom);
            in_mask  = 4'($urandom);
            in_vec   = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic drain();
        idle(1);
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic rand_beat();
        logic [L*DW-1:0] v;
        for (int i = 0; i < int'(L); i++)
            v[i*DW +: DW] = $urandom | (($urandom % 2) != 0 ? 32'hFFFF_FF00 : 32'h0);
        send(($urandom % 4) == 0, ($urandom % 3) == 0, 2'($urandom), 4'($urandom), v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_vec", out_vec, 32'h0);
        chk("rst_out_busy", 32'(out_busy), 32'd0);
        rst = 1'b1;
        idle(2);

        // AND single beat
        send(1, 1, AND, 4'hF, {32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFFF_0000});
        drain();
        chk("t1_and", out_vec, 32'hF000_0000);

        // XOR over two beats with a bubble
        send(1, 0, XOR, 4'hF, {32'h8, 32'h4, 32'h2, 32'h1});
        idle(1);
        chk("t2_busy_open", 32'(out_busy), 32'd1);
        send(0, 1, XOR, 4'hF, {32'h80, 32'h40, 32'h20, 32'h10});
        drain();
        chk("t2_xor", out_vec, 32'h0000_00FF);

        // Masking and opcode 00
        send(1, 1, OR, 4'b0101, {32'h8, 32'h4, 32'h2, 32'h1});
        drain();
        chk("t3_or_mask", out_vec, 32'h0000_0005);
        send(1, 1, AND, 4'b0000, {$urandom, $urandom, $urandom, $urandom});
        drain();
        chk("t3_and_nomask", out_vec, 32'hFFFF_FFFF);
        send(1, 1, ZRO, 4'hF, {32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFF, 32'hA5A5_A5A5});
        drain();
        chk("t3_op00", out_vec, 32'h0);

        // Back-to-back single-beat reductions
        send(1, 1, AND, 4'hF, {32'h00FF_FF00, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        send(1, 1, OR,  4'hF, {32'h1000_0000, 32'h0100_0000, 32'h0010_0000, 32'h0001_0000});
        send(1, 1, XOR, 4'hF, {32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0000_0001});
        send(1, 1, OR,  4'hF, {32'h0, 32'h0, 32'h0, 32'hA5A5_0000});
        drain();
        chk("t4_last", out_vec, 32'hA5A5_0000);

        // Open reduction restarted by a new first beat
        send(1, 0, OR, 4'hF, {32'h0, 32'h0, 32'h0, 32'h1});
        send(1, 1, OR, 4'hF, {32'h0, 32'h0, 32'h0, 32'h2});
        drain();
        chk("t5_restart", out_vec, 32'h0000_0002);

        // Reset while a last beat is in the tree
        send(1, 1, AND, 4'hF, {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678});
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_vec", out_vec, 32'h0);
        chk("t6_rst_busy", 32'(out_busy), 32'd0);
        sb.delete();
        m_open   = 1'b0;
        last_exp = '0;
        @(negedge clk);
        rst = 1'b1;
        idle(8);
        chk("t6_post_busy", 32'(out_busy), 32'd0);

        // Random beats, bubbles, restarts and opcodes
        repeat (1500) begin
            if (($urandom % 4) != 0) rand_beat();
            else idle(1);
        end
        send(1, 1, XOR, 4'hF, {$urandom, $urandom, $urandom, $urandom});
        drain();
        idle(2);
        chk("final_busy", 32'(out_busy), 32'd0);
        chk("final_queue", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
